sine_coord_gen: RTL and testbench
=================================

SINE_COORD_GEN -- requirements
Module: sine_coord_gen

Interface
REQ-001 SHALL have parameter CELL_SHIFT, default 3: log2 of the cell size in pixels; sets the pixel-to-cell scaling on both axes.
REQ-002 SHALL have parameter Y_ORIGIN, default 160: first vpos line of the sine band.
REQ-003 SHALL have parameter BAND_ROWS, default 22: band height in cells, at most 32.
REQ-004 SHALL have one clock and a synchronous, active-high reset: ports clk and rst, all state on the rising edge of clk.
REQ-005 clk  input  1  system/pixel clock.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 hpos  input  10  current VGA column from the sync generator.
REQ-008 vpos  input  10  current VGA row from the sync generator.
REQ-009 display_on  input  1  high inside the visible area.
REQ-010 frame_tick  input  1  one-cycle pulse, once per frame, at frame start.
REQ-011 speed  input  2  scroll step select.
REQ-012 dir  input  1  scroll direction: 0 = increasing phase, 1 = decreasing phase.
REQ-013 pause  input  1  freeze request, sampled only on frame_tick.
REQ-014 x  output  6  cell column fed to the sine layer's x input.
REQ-015 y  output  5  cell row fed to the sine layer's y input.
REQ-016 layer_en  output  1  high when x/y are valid and the pixel lies inside the band.
REQ-017 phase  output  10  scroll phase accumulator: 6 integer bits [9:4], 4 fractional bits [3:0].

Function
REQ-018 SHALL implement an FSM with states WAIT, RUN and HOLD; reset enters WAIT.
REQ-019 FSM transitions, all evaluated only on frame_tick=1; no transition occurs on any other cycle:
- WAIT -> RUN; phase does not advance on this tick.
- RUN, pause=1 -> HOLD, no advance.
- RUN, pause=0 -> stays in RUN and advances.
- HOLD, pause=0 -> RUN and advances on the same tick.
- HOLD, pause=1 -> stays in HOLD, no advance.
REQ-020 Step size in 1/16 cells SHALL be speed 00->1, 01->2, 10->4, 11->8.
REQ-021 Advance SHALL be phase+step when dir=0 and phase-step when dir=1, modulo 1024 (wrap silently in both directions).
REQ-022 Column: cx = (hpos >> CELL_SHIFT)[5:0]; x = (cx + phase[9:4]) mod 64.
REQ-023 Row: in_band = (vpos >= Y_ORIGIN) and (((vpos - Y_ORIGIN) >> CELL_SHIFT) < BAND_ROWS).
- The comparison is done before the subtraction, so there is no underflow.
- y = ((vpos - Y_ORIGIN) >> CELL_SHIFT)[4:0] when in_band, else 0.
REQ-024 layer_en SHALL equal display_on AND in_band AND (state != WAIT).
REQ-025 x, y and layer_en SHALL be registered with exactly 1-cycle latency from hpos/vpos/display_on.
REQ-026 x and y SHALL be forced to 0 whenever the registered layer_en is 0.
REQ-027 The registered x/y of the cycle in which frame_tick is high SHALL use the pre-update phase; the new phase SHALL be visible in phase and used for x from the next cycle on.
REQ-028 speed and dir changes SHALL take effect at the next advancing frame_tick only.
REQ-029 frame_tick held high for multiple cycles SHALL advance once per high cycle; the sync generator guarantees single-cycle pulses.

Reset
REQ-030 With rst=1 at a clock edge, the block SHALL, on the next cycle:
- set state to WAIT and phase to 0;
- set x, y and layer_en to 0;
- take rst priority over frame_tick, pause and all other inputs.
REQ-031 After reset mid-operation, layer_en SHALL stay 0 until the first frame_tick following rst deassertion.

Verification
REQ-032 Reset: rst=1 for 2 cycles with display_on=1, vpos=200 -> x=0, y=0, layer_en=0, phase=0.
REQ-033 Scroll: one frame_tick to leave WAIT, then speed=3, dir=0, 3 ticks -> phase=24 (integer part 1). Then hpos=16, vpos=168, display_on=1 -> next cycle x=3, y=1, layer_en=1.
REQ-034 Wrap: from phase=0 in RUN, dir=1, speed=0, 1 tick -> phase=1023. Then hpos=8 -> x=0.
REQ-035 Band edges in RUN, display_on=1:
- vpos=159 -> layer_en=0.
- vpos=160 -> y=0, layer_en=1.
- vpos=335 -> y=21.
- vpos=336 -> layer_en=0, y=0.
REQ-036 Pause: pause=1 with a tick -> phase unchanged, state HOLD; further ticks with pause=1 -> no change; pause=0 with a tick -> phase advances by the step and state returns to RUN.
REQ-037 Mid-run reset: phase=100 in RUN, rst pulse -> phase=0, layer_en=0 until the next frame_tick, then layer_en follows band/display_on.

Source files
------------

// File: rtl/sine_coord_gen.sv
// Scrolling sine-band coordinate generator: maps VGA hpos/vpos to sine-layer
// cell coordinates, with a frame-rate phase accumulator driven by a small FSM.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   WAIT   | idle after reset; layer disabled until the first frame_tick
//   RUN    | scrolling; phase advances on every frame_tick with pause=0
//   HOLD   | frozen; phase is held until a frame_tick with pause=0
module sine_coord_gen #(
  parameter int CELL_SHIFT = 3,
  parameter int Y_ORIGIN   = 160,
  parameter int BAND_ROWS  = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       frame_tick,
  input  logic [1:0] speed,
  input  logic       dir,
  input  logic       pause,
  output logic [5:0] x,
  output logic [4:0] y,
  output logic       layer_en,
  output logic [9:0] phase
);

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0] r_state;
  logic [9:0] r_phase;
  logic [5:0] r_x;
  logic [4:0] r_y;
  logic       r_en;

  logic [1:0] w_state_nxt;
  logic       w_adv;
  logic [9:0] w_step;
  logic [9:0] w_phase_nxt;
  logic [5:0] w_cx;
  logic [5:0] w_x;
  logic [9:0] w_voff;
  logic [9:0] w_vrow;
  logic       w_in_band;
  logic       w_en;

  always_comb begin
    w_state_nxt = r_state;
    w_adv       = 1'b0;
    if (frame_tick) begin
      case (r_state)
        S_WAIT: w_state_nxt = S_RUN;
        S_RUN: begin
          if (pause) w_state_nxt = S_HOLD;
          else       w_adv       = 1'b1;
        end
        S_HOLD: begin
          if (!pause) begin
            w_state_nxt = S_RUN;
            w_adv       = 1'b1;
          end
        end
        default: w_state_nxt = S_WAIT;
      endcase
    end
  end

  // Step is in 1/16 cell units; 10-bit arithmetic wraps in both directions.
  assign w_step      = 10'd1 << speed;
  assign w_phase_nxt = !w_adv ? r_phase :
                       (dir ? r_phase - w_step : r_phase + w_step);

  assign w_cx = 6'(hpos >> CELL_SHIFT);
  assign w_x  = w_cx + r_phase[9:4];

  // Band test uses the >= compare first, so the wrapped subtraction is never used.
  assign w_voff    = vpos - 10'(Y_ORIGIN);
  assign w_vrow    = w_voff >> CELL_SHIFT;
  assign w_in_band = (vpos >= 10'(Y_ORIGIN)) && (w_vrow < 10'(BAND_ROWS));
  assign w_en      = display_on && w_in_band && (r_state != S_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_WAIT;
      r_phase <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_en    <= w_en;
      r_x     <= w_en ? w_x : '0;
      r_y     <= w_en ? w_vrow[4:0] : '0;
    end
  end

  assign x        = r_x;
  assign y        = r_y;
  assign layer_en = r_en;
  assign phase    = r_phase;

endmodule

// File: tb/tb_sine_coord_gen.sv
// Self-checking bench for sine_coord_gen: directed scenarios plus randomized
// traffic, all checked against a cycle-level behavioural model.
module tb_sine_coord_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       frame_tick;
  logic [1:0] speed;
  logic       dir;
  logic       pause;
  logic [5:0] x;
  logic [4:0] y;
  logic       layer_en;
  logic [9:0] phase;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: "started" means a frame_tick has been seen since reset; once
  // started, a tick with pause=0 advances and a tick with pause=1 freezes.
  bit m_started;
  int m_phase;

  sine_coord_gen dut (
    .clk       (clk),
    .rst       (rst),
    .hpos      (hpos),
    .vpos      (vpos),
    .display_on(display_on),
    .frame_tick(frame_tick),
    .speed     (speed),
    .dir       (dir),
    .pause     (pause),
    .x         (x),
    .y         (y),
    .layer_en  (layer_en),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: predict registered outputs from current inputs, clock, check.
  task automatic cyc();
    int  ex, ey, ee, row;
    bit  band;
    row  = (int'(vpos) - 160) / 8;
    band = (int'(vpos) >= 160) && (row < 22);
    ee   = (display_on && band && m_started) ? 1 : 0;
    ex   = ee ? (((int'(hpos) / 8) + (m_phase / 16)) % 64) : 0;
    ey   = ee ? row : 0;
    if (rst) begin
      ex = 0; ey = 0; ee = 0;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_started = 0;
      m_phase   = 0;
    end else if (frame_tick) begin
      if (!m_started) m_started = 1;
      else if (!pause) begin
        if (dir) m_phase = (m_phase + 1024 - (1 << speed)) % 1024;
        else     m_phase = (m_phase + (1 << speed)) % 1024;
      end
    end
    chk("x", int'(x), ex);
    chk("y", int'(y), ey);
    chk("layer_en", int'(layer_en), ee);
    chk("phase", int'(phase), m_phase);
  endtask

  task automatic tick_frame();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; hpos = '0; vpos = 10'd200; display_on = 1'b1;
    frame_tick = 1'b0; speed = 2'd0; dir = 1'b0; pause = 1'b0;
    m_started = 0; m_phase = 0;
    #2;

    // Reset with display active inside the band
    do_reset();
    chk("rst_layer_en", int'(layer_en), 0);
    chk("rst_phase", int'(phase), 0);

    // Scroll: leave WAIT, then three speed-3 forward ticks
    tick_frame();
    speed = 2'd3; dir = 1'b0;
    repeat (3) tick_frame();
    chk("scroll_phase", int'(phase), 24);
    hpos = 10'd16; vpos = 10'd168; display_on = 1'b1;
    cyc();
    chk("scroll_x", int'(x), 3);
    chk("scroll_y", int'(y), 1);
    chk("scroll_en", int'(layer_en), 1);

    // Backward wrap from phase 0
    do_reset();
    tick_frame();
    dir = 1'b1; speed = 2'd0;
    tick_frame();
    chk("wrap_phase", int'(phase), 1023);
    hpos = 10'd8;
    cyc();
    chk("wrap_x", int'(x), 0);

    // Band edges
    dir = 1'b0;
    vpos = 10'd159; cyc(); chk("edge159_en", int'(layer_en), 0);
    vpos = 10'd160; cyc(); chk("edge160_y", int'(y), 0); chk("edge160_en", int'(layer_en), 1);
    vpos = 10'd335; cyc(); chk("edge335_y", int'(y), 21);
    vpos = 10'd336; cyc(); chk("edge336_en", int'(layer_en), 0); chk("edge336_y", int'(y), 0);

    // Pause / hold / resume
    vpos = 10'd200; speed = 2'd2;
    tick_frame();
    pause = 1'b1;
    repeat (3) tick_frame();
    chk("hold_phase", int'(phase), 3);
    pause = 1'b0;
    tick_frame();
    chk("resume_phase", int'(phase), 7);

    // Mid-run reset at phase 100
    do_reset();
    tick_frame();
    speed = 2'd3;
    repeat (12) tick_frame();
    speed = 2'd2;
    tick_frame();
    chk("pre_rst_phase", int'(phase), 100);
    rst = 1'b1; cyc(); rst = 1'b0;
    repeat (4) cyc();
    chk("post_rst_en", int'(layer_en), 0);
    tick_frame();
    cyc();
    chk("post_tick_en", int'(layer_en), 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 149) == 0);
      frame_tick = ($urandom_range(0, 5) == 0);
      pause      = ($urandom_range(0, 3) == 0);
      speed      = 2'($urandom_range(0, 3));
      dir        = 1'($urandom_range(0, 1));
      display_on = ($urandom_range(0, 4) != 0);
      hpos       = 10'($urandom_range(0, 1023));
      vpos       = 10'($urandom_range(140, 360));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
